// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } pc_state_e;

    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_SEQ,
        SRC_BRANCH,
        SRC_JUMP,
        SRC_RET,
        SRC_ERET,
        SRC_TRAP
    } pc_src_e;

    // Low-bit mask a legal target must have clear; STEP is a power of two.
    function automatic int unsigned align_mask(input int unsigned step);
        return step - 1;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: pushing when full overwrites the oldest entry.
module pc_ras #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [XLEN-1:0]          i_data,
    output logic [XLEN-1:0]          o_top,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [XLEN-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_ptr;
    logic [AW:0]     r_count;
    logic [AW-1:0]   w_ptr_dec;

    // r_ptr is the next free slot, so the newest entry sits one below it.
    assign w_ptr_dec = r_ptr - 1'b1;
    assign o_top     = r_mem[w_ptr_dec];
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (i_push && !i_pop) begin
            r_mem[r_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (i_pop && !o_empty) begin
            r_ptr   <= w_ptr_dec;
            r_count <= r_count - 1'b1;
        end else if (i_push) begin
            r_ptr <= r_ptr + 1'b1;
            if (!o_full) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC generator with stall, redirect, trap/eret and halt control.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     STEP         = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h80),
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_ready_i,
    input  logic            halt_i,
    input  logic            resume_i,
    input  logic            branch_i,
    input  logic [XLEN-1:0] branch_tgt_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_tgt_i,
    input  logic            call_i,
    input  logic            ret_i,
    input  logic [XLEN-1:0] ret_tgt_i,
    input  logic            trap_i,
    input  logic            eret_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] epc_o,
    output logic            misalign_o
);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(align_mask(STEP));
    localparam logic [XLEN-1:0] STEP_INC   = XLEN'(STEP);

    pc_state_e       r_state, w_state_next;
    logic [XLEN-1:0] r_pc, w_pc_next;
    logic [XLEN-1:0] r_epc, w_epc_next;
    logic            r_redirect, w_redirect_next;
    logic            r_misalign, w_misalign_next;
    pc_src_e         w_src;
    logic [XLEN-1:0] w_tgt;
    logic [XLEN-1:0] w_ret_tgt;
    logic            w_tgt_misaligned;

`ifdef PC_RAS_EN
    logic                         w_push, w_pop;
    logic                         w_ras_empty, w_ras_full;
    logic [XLEN-1:0]              w_ras_top;
    logic [$clog2(RAS_DEPTH):0]   w_ras_count;
    logic                         w_unused_ras;

    // A misaligned call traps, so its return address is never pushed.
    assign w_push = (w_src == SRC_JUMP) && call_i && !w_tgt_misaligned;
    assign w_pop  = (w_src == SRC_RET) && !w_ras_empty;

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (r_pc + STEP_INC),
        .o_top   (w_ras_top),
        .o_empty (w_ras_empty),
        .o_full  (w_ras_full),
        .o_count (w_ras_count)
    );

    assign w_ret_tgt    = w_ras_empty ? ret_tgt_i : w_ras_top;
    assign w_unused_ras = &{1'b0, w_ras_full, w_ras_count};
`else
    logic w_unused_call;

    assign w_ret_tgt     = ret_tgt_i;
    assign w_unused_call = &{1'b0, call_i};
`endif

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_epc_next       = r_epc;
        w_redirect_next  = 1'b0;
        w_misalign_next  = 1'b0;
        w_src            = SRC_HOLD;
        w_tgt            = '0;
        w_tgt_misaligned = 1'b0;

        unique case (r_state)
            ST_BOOT: w_state_next = ST_RUN;
            ST_RUN: begin
                if (halt_i) w_state_next = ST_HALT;
                if (trap_i)                      w_src = SRC_TRAP;
                else if (eret_i)                 w_src = SRC_ERET;
                else if (ret_i)                  w_src = SRC_RET;
                else if (jump_i)                 w_src = SRC_JUMP;
                else if (branch_i)               w_src = SRC_BRANCH;
                else if (fetch_ready_i)          w_src = SRC_SEQ;
            end
            ST_HALT: begin
                if (resume_i) w_state_next = ST_RUN;
                if (trap_i)   w_src = SRC_TRAP;
            end
            default: w_state_next = ST_BOOT;
        endcase

        unique case (w_src)
            SRC_BRANCH: w_tgt = branch_tgt_i;
            SRC_JUMP:   w_tgt = jump_tgt_i;
            SRC_RET:    w_tgt = w_ret_tgt;
            default:    w_tgt = '0;
        endcase
        w_tgt_misaligned = |(w_tgt & ALIGN_MASK);

        unique case (w_src)
            SRC_SEQ: w_pc_next = r_pc + STEP_INC;
            SRC_TRAP: begin
                w_epc_next      = r_pc;
                w_pc_next       = TRAP_VECTOR;
                w_redirect_next = 1'b1;
            end
            SRC_ERET: begin
                w_pc_next       = r_epc;
                w_redirect_next = 1'b1;
            end
            SRC_BRANCH, SRC_JUMP, SRC_RET: begin
                w_redirect_next = 1'b1;
                if (w_tgt_misaligned) begin
                    w_pc_next       = TRAP_VECTOR;
                    w_epc_next      = w_tgt;
                    w_misalign_next = 1'b1;
                end else begin
                    w_pc_next = w_tgt;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_VECTOR;
            r_epc      <= '0;
            r_redirect <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_epc      <= w_epc_next;
            r_redirect <= w_redirect_next;
            r_misalign <= w_misalign_next;
        end
    end

    assign pc_o       = r_pc;
    assign epc_o      = r_epc;
    assign pc_valid_o = (r_state == ST_RUN);
    assign redirect_o = r_redirect;
    assign misalign_o = r_misalign;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer; expectations follow the RAS build when PC_RAS_EN is defined.
module tb_pc_sequencer;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        valid;
        logic        redirect;
        logic        misalign;
    } obs_t;

    typedef struct packed {
        logic [9:0]  flags;
        logic [31:0] btgt;
        logic [31:0] jtgt;
        logic [31:0] rtgt;
    } stim_t;

    localparam logic [9:0] F_STALL = 10'd1;
    localparam logic [9:0] F_HALT  = 10'd2;
    localparam logic [9:0] F_RES   = 10'd4;
    localparam logic [9:0] F_BR    = 10'd8;
    localparam logic [9:0] F_JMP   = 10'd16;
    localparam logic [9:0] F_CALL  = 10'd32;
    localparam logic [9:0] F_RET   = 10'd64;
    localparam logic [9:0] F_TRAP  = 10'd128;
    localparam logic [9:0] F_ERET  = 10'd256;
    localparam logic [9:0] F_RST   = 10'd512;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_ready_i = 1'b0, halt_i = 1'b0, resume_i = 1'b0;
    logic        branch_i = 1'b0, jump_i = 1'b0, call_i = 1'b0, ret_i = 1'b0;
    logic        trap_i = 1'b0, eret_i = 1'b0;
    logic [31:0] branch_tgt_i = '0, jump_tgt_i = '0, ret_tgt_i = '0;
    logic [31:0] pc_o, epc_o;
    logic        pc_valid_o, redirect_o, misalign_o;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];
    obs_t got_q[$];

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_ready_i (fetch_ready_i),
        .halt_i        (halt_i),
        .resume_i      (resume_i),
        .branch_i      (branch_i),
        .branch_tgt_i  (branch_tgt_i),
        .jump_i        (jump_i),
        .jump_tgt_i    (jump_tgt_i),
        .call_i        (call_i),
        .ret_i         (ret_i),
        .ret_tgt_i     (ret_tgt_i),
        .trap_i        (trap_i),
        .eret_i        (eret_i),
        .pc_o          (pc_o),
        .pc_valid_o    (pc_valid_o),
        .redirect_o    (redirect_o),
        .epc_o         (epc_o),
        .misalign_o    (misalign_o)
    );

    function automatic stim_t mk(input logic [9:0] f, input logic [31:0] b = '0,
                                 input logic [31:0] j = '0, input logic [31:0] r = '0);
        stim_t s;
        s.flags = f; s.btgt = b; s.jtgt = j; s.rtgt = r;
        return s;
    endfunction

    function automatic obs_t ex(input logic [31:0] pc, input logic [31:0] epc,
                                input logic v, input logic r, input logic m);
        obs_t o;
        o.pc = pc; o.epc = epc; o.valid = v; o.redirect = r; o.misalign = m;
        return o;
    endfunction

    // Drive one cycle of stimulus, queue its expected result, capture what the DUT shows after the edge.
    task automatic step(input stim_t s, input obs_t e);
        obs_t g;
        @(negedge clk);
        reset         = ~s.flags[9];
        fetch_ready_i = ~s.flags[0];
        halt_i        = s.flags[1];
        resume_i      = s.flags[2];
        branch_i      = s.flags[3];
        jump_i        = s.flags[4];
        call_i        = s.flags[5];
        ret_i         = s.flags[6];
        trap_i        = s.flags[7];
        eret_i        = s.flags[8];
        branch_tgt_i  = s.btgt;
        jump_tgt_i    = s.jtgt;
        ret_tgt_i     = s.rtgt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g.pc = pc_o; g.epc = epc_o; g.valid = pc_valid_o;
        g.redirect = redirect_o; g.misalign = misalign_o;
        got_q.push_back(g);
        $display("cycle: flags=%03h pc=%h epc=%h valid=%b redirect=%b misalign=%b",
                 s.flags, pc_o, epc_o, pc_valid_o, redirect_o, misalign_o);
    endtask

    task automatic test_reset();
        obs_t e, g;
        int   idx = 0;
        step(mk(F_RST | F_BR | F_TRAP, 32'h40), ex(32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
        step(mk(F_RST), ex(32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++) step(mk('0), ex(32'(i * 4), 32'h0, 1'b1, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset[%0d]: got pc=%h epc=%h v=%b r=%b m=%b, expected pc=%h epc=%h v=%b r=%b m=%b",
                         idx, g.pc, g.epc, g.valid, g.redirect, g.misalign, e.pc, e.epc, e.valid, e.redirect, e.misalign);
            end
            idx++;
        end
    endtask

    task automatic test_stall_branch();
        obs_t e, g;
        int   idx = 0;
        for (int i = 0; i < 3; i++) step(mk(F_STALL), ex(32'h10, 32'h0, 1'b1, 1'b0, 1'b0));
        step(mk(F_STALL | F_BR, 32'h40), ex(32'h40, 32'h0, 1'b1, 1'b1, 1'b0));
        step(mk(F_BR, 32'h20), ex(32'h20, 32'h0, 1'b1, 1'b1, 1'b0));
        step(mk('0), ex(32'h24, 32'h0, 1'b1, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL stall_branch[%0d]: got pc=%h epc=%h v=%b r=%b m=%b, expected pc=%h epc=%h v=%b r=%b m=%b",
                         idx, g.pc, g.epc, g.valid, g.redirect, g.misalign, e.pc, e.epc, e.valid, e.redirect, e.misalign);
            end
            idx++;
        end
    endtask

    task automatic test_trap_eret();
        obs_t e, g;
        int   idx = 0;
        step(mk(F_TRAP | F_JMP, 32'h0, 32'h200), ex(32'h80, 32'h24, 1'b1, 1'b1, 1'b0));
        step(mk('0), ex(32'h84, 32'h24, 1'b1, 1'b0, 1'b0));
        step(mk(F_ERET), ex(32'h24, 32'h24, 1'b1, 1'b1, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL trap_eret[%0d]: got pc=%h epc=%h v=%b r=%b m=%b, expected pc=%h epc=%h v=%b r=%b m=%b",
                         idx, g.pc, g.epc, g.valid, g.redirect, g.misalign, e.pc, e.epc, e.valid, e.redirect, e.misalign);
            end
            idx++;
        end
    endtask

    task automatic test_misalign_wrap();
        obs_t e, g;
        int   idx = 0;
        step(mk(F_JMP, 32'h0, 32'h102), ex(32'h80, 32'h102, 1'b1, 1'b1, 1'b1));
        step(mk('0), ex(32'h84, 32'h102, 1'b1, 1'b0, 1'b0));
        step(mk(F_STALL | F_BR, 32'h41), ex(32'h80, 32'h41, 1'b1, 1'b1, 1'b1));
        step(mk(F_BR, 32'hFFFF_FFFC), ex(32'hFFFF_FFFC, 32'h41, 1'b1, 1'b1, 1'b0));
        step(mk('0), ex(32'h0, 32'h41, 1'b1, 1'b0, 1'b0));
        step(mk('0), ex(32'h4, 32'h41, 1'b1, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL misalign_wrap[%0d]: got pc=%h epc=%h v=%b r=%b m=%b, expected pc=%h epc=%h v=%b r=%b m=%b",
                         idx, g.pc, g.epc, g.valid, g.redirect, g.misalign, e.pc, e.epc, e.valid, e.redirect, e.misalign);
            end
            idx++;
        end
    endtask

    task automatic test_priority_back_to_back();
        obs_t e, g;
        int   idx = 0;
        step(mk(F_TRAP | F_ERET | F_RET | F_JMP | F_BR, 32'h100, 32'h200, 32'h300),
             ex(32'h80, 32'h4, 1'b1, 1'b1, 1'b0));
        step(mk(F_ERET | F_RET | F_JMP | F_BR, 32'h100, 32'h200, 32'h300), ex(32'h4, 32'h4, 1'b1, 1'b1, 1'b0));
        step(mk(F_RET | F_JMP | F_BR, 32'h100, 32'h200, 32'h300), ex(32'h300, 32'h4, 1'b1, 1'b1, 1'b0));
        step(mk(F_JMP | F_BR, 32'h100, 32'h200), ex(32'h200, 32'h4, 1'b1, 1'b1, 1'b0));
        step(mk(F_BR, 32'h500), ex(32'h500, 32'h4, 1'b1, 1'b1, 1'b0));
        step(mk(F_STALL | F_BR, 32'h600), ex(32'h600, 32'h4, 1'b1, 1'b1, 1'b0));
        step(mk('0), ex(32'h604, 32'h4, 1'b1, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL priority[%0d]: got pc=%h epc=%h v=%b r=%b m=%b, expected pc=%h epc=%h v=%b r=%b m=%b",
                         idx, g.pc, g.epc, g.valid, g.redirect, g.misalign, e.pc, e.epc, e.valid, e.redirect, e.misalign);
            end
            idx++;
        end
    endtask

    task automatic test_call_ret();
        obs_t        e, g;
        int          idx = 0;
        logic [31:0] exp_pc;
        step(mk(F_BR, 32'h0), ex(32'h0, 32'h4, 1'b1, 1'b1, 1'b0));
        for (int i = 0; i < 5; i++)
            step(mk(F_CALL | F_JMP, 32'h0, 32'((i + 1) * 16)), ex(32'((i + 1) * 16), 32'h4, 1'b1, 1'b1, 1'b0));
        for (int i = 0; i < 5; i++) begin
`ifdef PC_RAS_EN
            exp_pc = (i < 4) ? 32'(32'h44 - i * 16) : 32'h700;
`else
            exp_pc = 32'h700;
`endif
            step(mk(F_RET, 32'h0, 32'h0, 32'h700), ex(exp_pc, 32'h4, 1'b1, 1'b1, 1'b0));
        end
        step(mk(F_CALL | F_JMP, 32'h0, 32'h800), ex(32'h800, 32'h4, 1'b1, 1'b1, 1'b0));
`ifdef PC_RAS_EN
        exp_pc = 32'h704;
`else
        exp_pc = 32'hA00;
`endif
        step(mk(F_RET | F_CALL | F_JMP, 32'h0, 32'h900, 32'hA00), ex(exp_pc, 32'h4, 1'b1, 1'b1, 1'b0));
        step(mk(F_RET, 32'h0, 32'h0, 32'hB00), ex(32'hB00, 32'h4, 1'b1, 1'b1, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL call_ret[%0d]: got pc=%h epc=%h v=%b r=%b m=%b, expected pc=%h epc=%h v=%b r=%b m=%b",
                         idx, g.pc, g.epc, g.valid, g.redirect, g.misalign, e.pc, e.epc, e.valid, e.redirect, e.misalign);
            end
            idx++;
        end
    endtask

    task automatic test_halt();
        obs_t e, g;
        int   idx = 0;
        step(mk(F_HALT), ex(32'hB04, 32'h4, 1'b0, 1'b0, 1'b0));
        step(mk(F_BR, 32'h100), ex(32'hB04, 32'h4, 1'b0, 1'b0, 1'b0));
        step(mk(F_ERET | F_JMP, 32'h0, 32'h200), ex(32'hB04, 32'h4, 1'b0, 1'b0, 1'b0));
        step(mk('0), ex(32'hB04, 32'h4, 1'b0, 1'b0, 1'b0));
        step(mk(F_TRAP | F_BR, 32'h100), ex(32'h80, 32'hB04, 1'b0, 1'b1, 1'b0));
        step(mk(F_HALT | F_RES), ex(32'h80, 32'hB04, 1'b1, 1'b0, 1'b0));
        step(mk('0), ex(32'h84, 32'hB04, 1'b1, 1'b0, 1'b0));
        step(mk(F_HALT), ex(32'h88, 32'hB04, 1'b0, 1'b0, 1'b0));
        step(mk(F_RST | F_RES), ex(32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
        step(mk('0), ex(32'h0, 32'h0, 1'b1, 1'b0, 1'b0));
        step(mk('0), ex(32'h4, 32'h0, 1'b1, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL halt[%0d]: got pc=%h epc=%h v=%b r=%b m=%b, expected pc=%h epc=%h v=%b r=%b m=%b",
                         idx, g.pc, g.epc, g.valid, g.redirect, g.misalign, e.pc, e.epc, e.valid, e.redirect, e.misalign);
            end
            idx++;
        end
    endtask

    initial begin
        test_reset();
        test_stall_branch();
        test_trap_eret();
        test_misalign_wrap();
        test_priority_back_to_back();
        test_call_ret();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
